// File: rtl/seq_mac_pkg.sv
// Shared constants and types for the sequential-multiplier product collector.
package seq_mac_pkg;
   localparam int P         = 2;
   localparam int MAX_WIDTH = 16;

   typedef logic [4:0] cnt_t;
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} collect_state_e;
endpackage

// File: rtl/prod_collect.sv
// Assembles a 2w-bit product from P-bit chunks (LS chunk first), sign-extends
// it and hands it out through a one-entry valid/ready output slot.
module prod_collect #(
   parameter int P         = seq_mac_pkg::P,
   parameter int MAX_WIDTH = seq_mac_pkg::MAX_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [4:0]             width_i,
   input  logic                   chunk_valid_i,
   input  logic [P-1:0]           chunk_i,
   output logic                   busy_o,
   output logic [2*MAX_WIDTH-1:0] result_o,
   output logic                   result_valid_o,
   input  logic                   result_ready_i,
   output logic                   err_o
);
   import seq_mac_pkg::*;

   localparam int RW = 2 * MAX_WIDTH;

   collect_state_e r_state, w_state_nxt;
   cnt_t           r_cnt, w_cnt_nxt;
   logic [4:0]     r_w, w_w_nxt, w_w_latch;
   logic [RW-1:0]  r_asm, w_asm_nxt, w_asm_chunk, w_ext, r_result;
   logic           r_valid, r_err, w_err_nxt;
   logic           w_width_ok, w_last, w_slot_free, w_load, w_sign;

   assign w_width_ok  = (width_i != 5'd0) && !width_i[0] && (width_i <= 5'(MAX_WIDTH));
   assign w_w_latch   = w_width_ok ? width_i : 5'(MAX_WIDTH);
   assign w_last      = (r_cnt == r_w - 5'd1);
   assign w_slot_free = !r_valid || result_ready_i;

   // Assembly with the current chunk merged in, and its sign-extended view.
   // In HOLD no chunk is merged, so the extension sees the held product.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_asm_chunk = r_asm;
      if (r_state == COLLECT && chunk_valid_i) begin
         for (int i = 0; i < RW / P; i++) begin
            if (r_cnt == cnt_t'(i)) w_asm_chunk[i*P +: P] = chunk_i;
         end
      end
      w_sign = 1'b0;
      for (int i = 0; i < RW; i++) begin
         if (i == 2 * int'(r_w) - 1) w_sign = w_asm_chunk[i];
      end
      for (int i = 0; i < RW; i++) begin
         w_ext[i] = (i < 2 * int'(r_w)) ? w_asm_chunk[i] : w_sign;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_w_nxt     = r_w;
      w_asm_nxt   = r_asm;
      w_err_nxt   = r_err;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_asm_nxt   = '0;
               w_cnt_nxt   = '0;
               w_w_nxt     = w_w_latch;
               w_state_nxt = COLLECT;
               if (!w_width_ok) w_err_nxt = 1'b1;
            end
            if (chunk_valid_i) w_err_nxt = 1'b1;
         end
         COLLECT: begin
            if (start_i) begin
               w_asm_nxt   = '0;
               w_cnt_nxt   = '0;
               w_w_nxt     = w_w_latch;
               w_err_nxt   = 1'b1;
            end else if (chunk_valid_i) begin
               w_asm_nxt = w_asm_chunk;
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_slot_free) begin
                     w_load      = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 5'd1;
               end
            end
         end
         HOLD: begin
            if (start_i || chunk_valid_i) w_err_nxt = 1'b1;
            // The slot is full on entry, so ready means handshake plus reload.
            if (result_ready_i) begin
               w_load      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_w      <= '0;
         r_asm    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_w     <= w_w_nxt;
         r_asm   <= w_asm_nxt;
         r_err   <= w_err_nxt;
         if (w_load) begin
            r_result <= w_ext;
            r_valid  <= 1'b1;
         end else if (r_valid && result_ready_i) begin
            r_valid  <= 1'b0;
         end
      end
   end

   assign busy_o         = (r_state != IDLE);
   assign result_o       = r_result;
   assign result_valid_o = r_valid;
   assign err_o          = r_err;
endmodule

// File: doc/prod_collect.md
PROD_COLLECT -- requirements
Module: prod_collect

Interface
REQ-001 Parameter P SHALL be 2: bits per product chunk.
REQ-002 Parameter MAX_WIDTH SHALL default to 16: maximum operand width in bits.
REQ-003 Port clk_i SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst_i SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start_i SHALL be an input, 1 bit: begin a new product and latch width_i.
REQ-006 Port width_i SHALL be an input, 5 bits: operand width w; legal values are even, 2..MAX_WIDTH.
REQ-007 Port chunk_valid_i SHALL be an input, 1 bit: chunk_i carries the next product chunk this cycle.
REQ-008 Port chunk_i SHALL be an input, P bits: product chunk, least significant chunk first.
REQ-009 Port busy_o SHALL be an output, 1 bit: collector is not IDLE; upstream must not issue start_i.
REQ-010 Port result_o SHALL be an output, 2*MAX_WIDTH bits: assembled product, sign-extended.
REQ-011 Port result_valid_o SHALL be an output, 1 bit: result_o is valid.
REQ-012 Port result_ready_i SHALL be an input, 1 bit: consumer accepts result_o.
REQ-013 Port err_o SHALL be an output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT and HOLD; busy_o SHALL be 1 in COLLECT and HOLD.
REQ-015 In IDLE, start_i SHALL clear the assembly register and the chunk counter, latch w, and move to COLLECT on the next cycle.
REQ-016 An illegal width_i (odd, 0, or greater than MAX_WIDTH) SHALL be latched as MAX_WIDTH and SHALL set err_o.
REQ-017 In COLLECT, each chunk_valid_i SHALL write chunk_i into assembly bits [cnt*P+P-1 : cnt*P] and then increment cnt.
REQ-018 A product SHALL consist of exactly w chunks (2w bits); the chunk with cnt = w-1 completes it.
REQ-019 On completion, result_o SHALL be bits [2w-1:0] of the assembly, sign-extended from bit 2w-1 to 2*MAX_WIDTH bits.
REQ-020 On completion, if the output slot is empty or drains in the same cycle (result_valid_o & result_ready_i), the result SHALL load into the slot on that edge and the FSM SHALL return to IDLE; otherwise the FSM SHALL go to HOLD.
REQ-021 In HOLD, the completed result SHALL load into the slot in the cycle result_ready_i=1, after which the FSM SHALL go to IDLE.
REQ-022 result_valid_o SHALL rise the cycle after a load and clear after a handshake that has no simultaneous load; result_o SHALL remain stable while result_valid_o=1 and result_ready_i=0.
REQ-023 A simultaneous handshake and load SHALL keep result_valid_o=1 and present the new result, giving back-to-back throughput.
REQ-024 Latency SHALL be 1 cycle from the final chunk_valid_i to result_valid_o when the slot is free.
REQ-025 start_i in COLLECT SHALL abort the current product, restart per REQ-015, and set err_o.
REQ-026 start_i in HOLD SHALL be ignored and SHALL set err_o.
REQ-027 chunk_valid_i in IDLE or HOLD SHALL be ignored and SHALL set err_o.
REQ-028 start_i and chunk_valid_i in the same IDLE cycle SHALL be treated as start_i only, with the chunk dropped and err_o set.
REQ-029 err_o SHALL clear only on reset.

Reset
REQ-030 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE, and cnt, the assembly register, the latched w, result_o, result_valid_o and err_o SHALL all clear to 0; busy_o SHALL be 0.
REQ-031 Reset mid-COLLECT or mid-HOLD SHALL discard the partial or held product, with no output emitted.

Structure
REQ-032 Package seq_mac_pkg SHALL hold P, MAX_WIDTH, the chunk-count type (5 bits), and the enum collect_state_e {IDLE, COLLECT, HOLD}.
REQ-033 The block SHALL be a single flat module; no sub-module is required, and the output slot is an inline register.

Verification
REQ-034 With w=4, chunks 01,00,11,11 and ready held 1 -> result_o=32'hFFFF_FFF1 (-15), result_valid_o for 1 cycle, 1 cycle after the last chunk.
REQ-035 With w=16 and 16 chunks forming 32'h0000_7FFF -> result_o=32'h0000_7FFF, cnt wraps back to 0, FSM in IDLE.
REQ-036 Two w=2 products (0x3 then 0xC) with ready=0 for 5 cycles -> first result held stable, FSM in HOLD with busy_o=1; on ready=1 the first handshakes, then 32'hFFFF_FFFC loads with no gap.
REQ-037 start_i after 2 of 4 chunks, then 4 new chunks 10,00,00,00 -> result_o=32'h0000_0002 and err_o=1.
REQ-038 width_i=5 -> treated as 16 (16 chunks required) and err_o=1; chunk_valid_i while IDLE -> ignored and err_o=1.
REQ-039 rst_i asserted in HOLD -> next cycle all outputs 0, FSM in IDLE, held result never appears.
